// File: rtl/acc_seq_ctrl.sv
// Accelerator sequencer: per channel, fetch the KSIZE x KSIZE kernel, stream the
// ifmap words to the conv engine, wait for the engine, and write results back.
module acc_seq_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int KSIZE  = 3,
  parameter int CH_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [ADDR_W-1:0]             cfg_wbase,
  input  logic [ADDR_W-1:0]             cfg_ibase,
  input  logic [ADDR_W-1:0]             cfg_obase,
  input  logic [ADDR_W-1:0]             cfg_ilen,
  input  logic [CH_W-1:0]               cfg_nch,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic [KSIZE*KSIZE*DATA_W-1:0] kernel_data,
  output logic                          kernel_valid,
  output logic [DATA_W-1:0]             conv_num,
  output logic                          conv_num_valid,
  input  logic                          conv_done,
  input  logic [15:0]                   res_data,
  input  logic                          res_valid,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [15:0]                   wr_data,
  output logic                          busy,
  output logic                          done,
  output logic [CH_W-1:0]               ch_idx,
  output logic [ADDR_W-1:0]             res_cnt
);

  localparam int NW = KSIZE * KSIZE;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

  typedef enum logic [2:0] {IDLE, WLOAD, WLAST, STREAM, DRAIN, NEXTCH} state_t;
  state_t state, state_nxt;

  // Read pointers run on across channels, so channel c naturally lands on
  // base + c*NW (weights) and base + c*ilen (ifmap) without a multiplier.
  logic [ADDR_W-1:0] w_addr, i_addr, obase_q, ilen_q, n_cnt;
  logic [CH_W-1:0]   nch_q, ch_inc;
  logic [KW-1:0]     k_cnt, kcap_idx_p1;
  logic              kcap_vld_p1, strm_vld_p1;
  logic              n_last, res_acc;

  always_comb begin
    state_nxt = state;
    ch_inc    = ch_idx + CH_W'(1);
    n_last    = (n_cnt == ilen_q - ADDR_W'(1));
    case (state)
      IDLE:    if (start) state_nxt = WLOAD;
      WLOAD:   if (abort) state_nxt = IDLE;
               else if (k_cnt == K_LAST) state_nxt = WLAST;
      WLAST:   if (abort) state_nxt = IDLE;
               else state_nxt = (ilen_q == '0) ? DRAIN : STREAM;
      STREAM:  if (abort) state_nxt = IDLE;
               else if (n_last) state_nxt = DRAIN;
      DRAIN:   if (abort) state_nxt = IDLE;
               else if (conv_done) state_nxt = NEXTCH;
      NEXTCH:  if (abort) state_nxt = IDLE;
               else state_nxt = (ch_inc == nch_q) ? IDLE : WLOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state == WLOAD) begin
      rd_en   = 1'b1;
      rd_addr = w_addr;
    end else if (state == STREAM) begin
      rd_en   = 1'b1;
      rd_addr = i_addr;
    end
    busy           = (state != IDLE);
    conv_num_valid = strm_vld_p1;
    conv_num       = strm_vld_p1 ? rd_data : '0;
    res_acc        = busy && res_valid && !abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      w_addr       <= '0;
      i_addr       <= '0;
      obase_q      <= '0;
      ilen_q       <= '0;
      nch_q        <= '0;
      n_cnt        <= '0;
      k_cnt        <= '0;
      kcap_idx_p1  <= '0;
      kcap_vld_p1  <= 1'b0;
      strm_vld_p1  <= 1'b0;
      kernel_data  <= '0;
      kernel_valid <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      done         <= 1'b0;
      ch_idx       <= '0;
      res_cnt      <= '0;
    end else begin
      state <= state_nxt;
      // p1: SRAM word for last cycle's read is on rd_data; steer it to kernel or stream
      kcap_vld_p1  <= (state == WLOAD) && !abort;
      kcap_idx_p1  <= k_cnt;
      strm_vld_p1  <= (state == STREAM) && !abort;
      kernel_valid <= (state == WLAST) && !abort;
      if (kcap_vld_p1)
        kernel_data[int'(kcap_idx_p1)*DATA_W +: DATA_W] <= rd_data;

      // p1: registered write-back of engine results
      wr_en <= res_acc;
      if (res_acc) begin
        wr_addr <= obase_q + res_cnt;
        wr_data <= res_data;
        res_cnt <= res_cnt + ADDR_W'(1);
      end

      case (state)
        IDLE: if (start) begin
          w_addr  <= cfg_wbase;
          i_addr  <= cfg_ibase;
          obase_q <= cfg_obase;
          ilen_q  <= cfg_ilen;
          nch_q   <= (cfg_nch == '0) ? CH_W'(1) : cfg_nch;
          k_cnt   <= '0;
          n_cnt   <= '0;
          ch_idx  <= '0;
          res_cnt <= '0;
          done    <= 1'b0;
        end
        WLOAD: begin
          w_addr <= w_addr + ADDR_W'(1);
          k_cnt  <= (k_cnt == K_LAST) ? '0 : k_cnt + KW'(1);
        end
        STREAM: begin
          i_addr <= i_addr + ADDR_W'(1);
          n_cnt  <= n_last ? '0 : n_cnt + ADDR_W'(1);
        end
        NEXTCH: if (!abort) begin
          ch_idx <= ch_inc;
          if (ch_inc == nch_q) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Self-checking bench for acc_seq_ctrl: SRAM model, event logger, and a
// schedule-level reference built from channel timing arithmetic.
module tb_acc_seq_ctrl;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int KSIZE  = 3;
  localparam int CH_W   = 4;
  localparam int NW     = KSIZE * KSIZE;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   start = 1'b0, abort = 1'b0;
  logic [ADDR_W-1:0]      cfg_wbase = '0, cfg_ibase = '0, cfg_obase = '0, cfg_ilen = '0;
  logic [CH_W-1:0]        cfg_nch = '0;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_W-1:0]      rd_data = '0;
  logic [NW*DATA_W-1:0]   kernel_data;
  logic                   kernel_valid;
  logic [DATA_W-1:0]      conv_num;
  logic                   conv_num_valid;
  logic                   conv_done = 1'b0;
  logic [15:0]            res_data = '0;
  logic                   res_valid = 1'b0;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [15:0]            wr_data;
  logic                   busy, done;
  logic [CH_W-1:0]        ch_idx;
  logic [ADDR_W-1:0]      res_cnt;

  acc_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .KSIZE(KSIZE), .CH_W(CH_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_wbase(cfg_wbase), .cfg_ibase(cfg_ibase), .cfg_obase(cfg_obase),
    .cfg_ilen(cfg_ilen), .cfg_nch(cfg_nch),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .kernel_data(kernel_data), .kernel_valid(kernel_valid),
    .conv_num(conv_num), .conv_num_valid(conv_num_valid),
    .conv_done(conv_done), .res_data(res_data), .res_valid(res_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .ch_idx(ch_idx), .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return {a, 3'b101, ~a, 3'b010};
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem_f(rd_addr);

  typedef struct { int cyc; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } ev_t;
  typedef struct { int cyc; logic [NW*DATA_W-1:0] kd; } kv_t;
  ev_t rd_log[$], cn_log[$], wr_log[$];
  kv_t kv_log[$];

  always @(negedge clk) begin
    if (rd_en)          rd_log.push_back('{cyc, rd_addr, 32'd0});
    if (conv_num_valid) cn_log.push_back('{cyc, 13'd0, conv_num});
    if (wr_en)          wr_log.push_back('{cyc, wr_addr, {16'd0, wr_data}});
    if (kernel_valid)   kv_log.push_back('{cyc, kernel_data});
  end

  int checks = 0, failures = 0;
  bit abort_toggle = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},     64'(busy), 64'd0);
    chk({tag, "_done"},     64'(done), 64'd0);
    chk({tag, "_rd_en"},    64'(rd_en), 64'd0);
    chk({tag, "_rd_addr"},  64'(rd_addr), 64'd0);
    chk({tag, "_kvalid"},   64'(kernel_valid), 64'd0);
    chk({tag, "_kdata"},    64'(|kernel_data), 64'd0);
    chk({tag, "_cn_valid"}, 64'(conv_num_valid), 64'd0);
    chk({tag, "_conv_num"}, 64'(conv_num), 64'd0);
    chk({tag, "_wr_en"},    64'(wr_en), 64'd0);
    chk({tag, "_wr_addr"},  64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"},  64'(wr_data), 64'd0);
    chk({tag, "_ch_idx"},   64'(ch_idx), 64'd0);
    chk({tag, "_res_cnt"},  64'(res_cnt), 64'd0);
  endtask

  // One complete job with conv_done held high (so DRAIN lasts one cycle).
  // Reference: channel c starts WLOAD at 1 + c*(NW+3+ilen) relative to start.
  task automatic run_cfg(input logic [ADDR_W-1:0] wb, input logic [ADDR_W-1:0] ib,
                         input logic [ADDR_W-1:0] ob, input logic [ADDR_W-1:0] il,
                         input logic [CH_W-1:0] nc, input int res_mode,
                         output int n_rd, output int n_kv, output int n_cn, output int done_cyc);
    int nch_eff, per, tdone, base, cnt, busy_err, e, s, rd0, kv0, cn0, wr0;
    ev_t exp_rd[$], exp_cn[$], exp_wr[$];
    kv_t exp_kv[$];
    logic [ADDR_W-1:0] a;
    logic [NW*DATA_W-1:0] kd;
    nch_eff = (nc == '0) ? 1 : int'(nc);
    per     = NW + 3 + int'(il);
    tdone   = 1 + nch_eff * per;
    for (int c = 0; c < nch_eff; c++) begin
      s  = 1 + c * per;
      kd = '0;
      for (int k = 0; k < NW; k++) begin
        a = wb + ADDR_W'(c * NW + k);
        exp_rd.push_back('{s + k, a, 32'd0});
        kd[k*DATA_W +: DATA_W] = mem_f(a);
      end
      exp_kv.push_back('{s + NW + 1, kd});
      for (int n = 0; n < int'(il); n++) begin
        a = ib + ADDR_W'(c * int'(il) + n);
        exp_rd.push_back('{s + NW + 1 + n, a, 32'd0});
        exp_cn.push_back('{s + NW + 2 + n, 13'd0, mem_f(a)});
      end
    end
    rd0 = rd_log.size(); kv0 = kv_log.size(); cn0 = cn_log.size(); wr0 = wr_log.size();
    @(posedge clk); #1;
    base = cyc; cnt = 0; busy_err = 0; done_cyc = -1;
    for (int r = 0; r <= tdone + 3; r++) begin
      if (busy !== ((r >= 1 && r < tdone) ? 1'b1 : 1'b0)) busy_err++;
      if (done_cyc < 0 && r >= 1 && done === 1'b1) done_cyc = r;
      start = (r == 0) || (r > 1 && r < tdone && $urandom_range(0, 7) == 0);
      abort = (r == 0) && abort_toggle;
      if (r == 0) begin
        cfg_wbase = wb; cfg_ibase = ib; cfg_obase = ob; cfg_ilen = il; cfg_nch = nc;
      end else begin
        cfg_wbase = ADDR_W'($urandom); cfg_ibase = ADDR_W'($urandom);
        cfg_obase = ADDR_W'($urandom); cfg_ilen = ADDR_W'($urandom);
        cfg_nch = CH_W'($urandom);
      end
      conv_done = 1'b1;
      if (res_mode == 1) begin
        res_valid = (r >= 2 && r <= 7);
        res_data  = 16'h3C00 + 16'(r - 2);
      end else begin
        res_valid = ($urandom_range(0, 2) == 0) || r == tdone - 1 || r == tdone;
        res_data  = 16'($urandom);
      end
      if (res_valid && r >= 1 && r < tdone) begin
        exp_wr.push_back('{base + r + 1, ob + ADDR_W'(cnt), {16'd0, res_data}});
        cnt++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; res_valid = 1'b0; conv_done = 1'b0;
    abort_toggle = ~abort_toggle;
    chk("busy_trace", 64'(busy_err), 64'd0);
    chk("done_cycle", 64'(done_cyc), 64'(tdone));
    chk("ch_idx_end", 64'(ch_idx), 64'(nch_eff));
    chk("res_cnt_end", 64'(res_cnt), 64'(cnt));
    n_rd = rd_log.size() - rd0;
    n_kv = kv_log.size() - kv0;
    n_cn = cn_log.size() - cn0;
    chk("rd_count", 64'(n_rd), 64'(exp_rd.size()));
    e = 0;
    for (int i = 0; i < n_rd && i < exp_rd.size(); i++)
      if (rd_log[rd0+i].cyc != base + exp_rd[i].cyc || rd_log[rd0+i].addr !== exp_rd[i].addr) e++;
    chk("rd_seq", 64'(e), 64'd0);
    chk("kv_count", 64'(n_kv), 64'(exp_kv.size()));
    e = 0;
    for (int i = 0; i < n_kv && i < exp_kv.size(); i++)
      if (kv_log[kv0+i].cyc != base + exp_kv[i].cyc || kv_log[kv0+i].kd !== exp_kv[i].kd) e++;
    chk("kv_seq", 64'(e), 64'd0);
    chk("cn_count", 64'(n_cn), 64'(exp_cn.size()));
    e = 0;
    for (int i = 0; i < n_cn && i < exp_cn.size(); i++)
      if (cn_log[cn0+i].cyc != base + exp_cn[i].cyc || cn_log[cn0+i].data !== exp_cn[i].data) e++;
    chk("cn_seq", 64'(e), 64'd0);
    chk("wr_count", 64'(wr_log.size() - wr0), 64'(exp_wr.size()));
    e = 0;
    for (int i = 0; i < wr_log.size() - wr0 && i < exp_wr.size(); i++)
      if (wr_log[wr0+i].cyc != exp_wr[i].cyc || wr_log[wr0+i].addr !== exp_wr[i].addr ||
          wr_log[wr0+i].data !== exp_wr[i].data) e++;
    chk("wr_seq", 64'(e), 64'd0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] wb, ib, ob, il;
    logic [CH_W-1:0]   nc;
    int                exp_rd, exp_kv, exp_cn, exp_done;
    logic [ADDR_W-1:0] exp_first, exp_last;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int n_rd, n_kv, n_cn, dcyc, rs, wr0, rdn;
    tbl[0] = '{13'd4079, 13'd0,    13'd100,  13'd480, 4'd1,  489, 1,  480, 493, 13'd4079, 13'd479};
    tbl[1] = '{13'd4079, 13'd0,    13'd200,  13'd4,   4'd3,  39,  3,  12,  49,  13'd4079, 13'd11};
    tbl[2] = '{13'd8190, 13'd8000, 13'd0,    13'd0,   4'd2,  18,  2,  0,   25,  13'd8190, 13'd15};
    tbl[3] = '{13'd10,   13'd8190, 13'd8000, 13'd5,   4'd0,  14,  1,  5,   18,  13'd10,   13'd2};
    tbl[4] = '{13'd0,    13'd100,  13'd8191, 13'd2,   4'd15, 165, 15, 30,  211, 13'd0,    13'd129};

    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      rs = rd_log.size();
      run_cfg(tbl[i].wb, tbl[i].ib, tbl[i].ob, tbl[i].il, tbl[i].nc, 0, n_rd, n_kv, n_cn, dcyc);
      chk("tbl_rd", 64'(n_rd), 64'(tbl[i].exp_rd));
      chk("tbl_kv", 64'(n_kv), 64'(tbl[i].exp_kv));
      chk("tbl_cn", 64'(n_cn), 64'(tbl[i].exp_cn));
      chk("tbl_done", 64'(dcyc), 64'(tbl[i].exp_done));
      if (n_rd > 0) begin
        chk("tbl_first_addr", 64'(rd_log[rs].addr), 64'(tbl[i].exp_first));
        chk("tbl_last_addr", 64'(rd_log[rd_log.size()-1].addr), 64'(tbl[i].exp_last));
      end
    end

    for (int i = 0; i < 6; i++)
      run_cfg(ADDR_W'($urandom), ADDR_W'($urandom), ADDR_W'($urandom),
              ADDR_W'($urandom_range(0, 40)), CH_W'($urandom_range(0, 5)), 0,
              n_rd, n_kv, n_cn, dcyc);

    // Six result pulses with known data land at obase..obase+5
    run_cfg(13'd0, 13'd0, 13'd100, 13'd4, 4'd1, 1, n_rd, n_kv, n_cn, dcyc);
    chk("res6_cnt", 64'(res_cnt), 64'd6);
    for (int i = 0; i < 6; i++) begin
      chk("res6_addr", 64'(wr_log[wr_log.size()-6+i].addr), 64'(100 + i));
      chk("res6_data", 64'(wr_log[wr_log.size()-6+i].data), 64'(16'h3C00 + i));
    end

    // conv_done outside DRAIN is ignored; DRAIN is entered at rel cycle 15
    cfg_wbase = 13'd50; cfg_ibase = 13'd60; cfg_obase = 13'd0; cfg_ilen = 13'd4; cfg_nch = 4'd1;
    @(posedge clk); #1;
    for (int r = 0; r <= 22; r++) begin
      start = (r == 0);
      conv_done = (r == 5 || r == 12 || r == 20);
      if (r == 20) begin
        chk("drain_busy", 64'(busy), 64'd1);
        chk("drain_ch", 64'(ch_idx), 64'd0);
        chk("drain_rd_en", 64'(rd_en), 64'd0);
      end
      if (r == 22) begin
        chk("drain_done", 64'(done), 64'd1);
        chk("drain_idle", 64'(busy), 64'd0);
        chk("drain_ch_end", 64'(ch_idx), 64'd1);
      end else begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0; conv_done = 1'b0;

    // Abort at stream read 50, then replay from channel 0
    cfg_wbase = 13'd4079; cfg_ibase = 13'd0; cfg_obase = 13'd300; cfg_ilen = 13'd480; cfg_nch = 4'd1;
    @(posedge clk); #1;
    for (int r = 0; r <= 62; r++) begin
      start = (r == 0);
      abort = (r == 61);
      res_valid = (r == 61);
      res_data = 16'hBEEF;
      if (r == 61) begin
        chk("abort_rd_en", 64'(rd_en), 64'd1);
        chk("abort_rd_addr", 64'(rd_addr), 64'd50);
      end
      if (r == 62) begin
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rd_off", 64'(rd_en), 64'd0);
        chk("abort_kv", 64'(kernel_valid), 64'd0);
        chk("abort_cnv", 64'(conv_num_valid), 64'd0);
        chk("abort_wr", 64'(wr_en), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
      end else begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0; abort = 1'b0; res_valid = 1'b0;
    run_cfg(13'd4079, 13'd0, 13'd300, 13'd480, 4'd1, 0, n_rd, n_kv, n_cn, dcyc);

    // Reset in the middle of streaming discards everything
    cfg_wbase = 13'd7; cfg_ibase = 13'd900; cfg_obase = 13'd40; cfg_ilen = 13'd20; cfg_nch = 4'd2;
    @(posedge clk); #1;
    for (int r = 0; r < 30; r++) begin
      start = (r == 0);
      res_valid = $urandom_range(0, 1) == 1;
      res_data = 16'($urandom);
      conv_done = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr0 = wr_log.size(); rdn = rd_log.size();
    for (int r = 0; r < 20; r++) begin
      res_valid = 1'b1; conv_done = 1'b1;
      @(posedge clk); #1;
    end
    res_valid = 1'b0; conv_done = 1'b0;
    chk("post_rst_wr", 64'(wr_log.size() - wr0), 64'd0);
    chk("post_rst_rd", 64'(rd_log.size() - rdn), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
